exec_divider: RTL and testbench
===============================

// Module: exec_divider
// PURPOSE
//  Iterative radix-2 restoring divider for the execute stage; implements UDIV (ALUControlE=5'b01110)
//  and SDIV (5'b01111). Sits beside the single-cycle ALU, downstream of the controller's E registers.
//  Holds the pipeline through stall_e until the quotient/remainder are ready.
//  Cancels cleanly on FlushE.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; iteration count equals WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high; sampled on rising edge of clk
//  start      in   1      E-stage instr is UDIV/SDIV and CondExE true; sampled only in IDLE
//  op_signed  in   1      1=SDIV, 0=UDIV; captured with start
//  dividend   in   WIDTH  SrcAE (forwarded); captured with start
//  divisor    in   WIDTH  SrcBE (forwarded); captured with start
//  flush      in   1      FlushE; aborts any operation in flight
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse; quotient/remainder valid this cycle
//  quotient   out  WIDTH  result, held from DONE until the next accepted start
//  remainder  out  WIDTH  result, held likewise
//  stall_e    out  1      stall F/D/E; = (start & IDLE & ~flush) | ITER | FIX
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, stall_e=0, quotient=0, remainder=0, counter=0.
//  States: IDLE, ITER, FIX, DONE.
//  IDLE:
//   - On start & ~flush, latch |dividend| and |divisor| (abs only if op_signed), q_neg and r_neg.
//   - If divisor==0, go to DONE. Otherwise clear partial remainder and counter, then go to ITER.
//  ITER: each cycle shift {rem,quo} left by 1; trial-subtract divisor; on no borrow keep the
//   difference and set quo[0]=1. Increment counter; after WIDTH iterations go to FIX.
//  FIX: negate quotient if q_neg (sign(a)^sign(b)); negate remainder if r_neg (sign(a)); go to DONE.
//  DONE:
//   - done=1, stall_e=0, so the E-stage instruction advances this cycle with the result.
//   - Next state is IDLE. A start in DONE is ignored; the pipeline presents the next DIV in a later IDLE cycle.
//  Latency: start in cycle 0 -> done in cycle WIDTH+2 (34 for WIDTH=32).
//   Divide-by-zero -> done in cycle 1.
//  Divide by zero (both ops): quotient=0, remainder=dividend (raw input value).
//  SDIV overflow: -2^(W-1) / -1 gives quotient=0x80000000, remainder=0. Wraps; no trap.
//  Abs of -2^(W-1) is computed in WIDTH bits unsigned, so it is exact. Arithmetic is modulo 2^WIDTH.
//  flush in any state: next state IDLE, no done. Outputs keep their previous values.
//   flush has priority over start and over the DONE transition.
//  start while busy: ignored; operands are not re-captured.
//  reset mid-operation: next cycle matches the post-reset values; no done pulse.
//  Flags: the divider does not drive ALUFlagsE; the S-bit is ignored for DIV.
// TESTING
//  1 UDIV 100/7, start cycle 0 -> stall_e 1 in cycles 0..33, done in cycle 34, q=14, r=2.
//  2 SDIV -100/7 -> q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2); SDIV 100/-7 -> q=-14, r=2.
//  3 UDIV 0x12345678/0 -> done in cycle 1, q=0, r=0x12345678, stall_e high only in cycle 0.
//  4 SDIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; UDIV 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//  5 flush at cycle 10 of a UDIV -> busy=0 from cycle 11, no done. A new start in cycle 12 completes normally.
//  6 reset at cycle 5 of an SDIV -> all outputs 0 in cycle 6. A start asserted during busy is never accepted.

Source files
------------

// File: rtl/exec_divider.sv
// exec_divider
//   Iterative radix-2 restoring divider for the execute stage (UDIV / SDIV).
//   One quotient bit per clock over WIDTH cycles, followed by a sign-fix
//   cycle and a one-cycle DONE. Divide-by-zero completes directly.
//   Ports:
//     clk, reset           rising-edge clock, synchronous active-high reset
//     start, op_signed     request (sampled only in IDLE) and signed select
//     dividend, divisor    operands, captured on an accepted start
//     flush                aborts any operation in flight (beats start/DONE)
//     busy, done           state != IDLE; one-cycle result-valid pulse
//     quotient, remainder  result, held until the next completed operation
//     stall_e              holds F/D/E while the divide is in progress
module exec_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             stall_e
);

  localparam int CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {Idle, Iter, Fix, Done} state_t;

  state_t           state, stateNext;
  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] remWork, quoWork, dvsWork;
  logic             qNeg, rNeg;
  logic             accept;
  logic [WIDTH:0]   trial;

  // Two's-complement negate in WIDTH bits; |-2^(W-1)| stays exact as unsigned.
  function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept = (state == Idle) && start && !flush;

  // Shift {rem,quo} left by one and trial-subtract; bit WIDTH is the borrow.
  assign trial = {remWork, quoWork[WIDTH-1]} - {1'b0, dvsWork};

  always_comb begin
    stateNext = state;
    busy      = (state != Idle);
    done      = (state == Done);
    stall_e   = accept || (state == Iter) || (state == Fix);
    unique case (state)
      Idle:    if (accept) stateNext = (divisor == '0) ? Done : Iter;
      Iter:    if (count == CntW'(WIDTH - 1)) stateNext = Fix;
      Fix:     stateNext = Done;
      Done:    stateNext = Idle;
      default: stateNext = Idle;
    endcase
    if (flush) stateNext = Idle;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= Idle;
    else       state <= stateNext;
  end

  // Counter and architecturally visible results: cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (accept) begin
        count <= '0;
        if (divisor == '0) begin
          quotient  <= '0;
          remainder <= dividend;
        end
      end else if (state == Iter && !flush) begin
        count <= count + CntW'(1);
      end
      if (state == Fix && !flush) begin
        quotient  <= condNeg(quoWork, qNeg);
        remainder <= condNeg(remWork, rNeg);
      end
    end
  end

  // Working datapath: always loaded on accept before use, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      quoWork <= condNeg(dividend, op_signed && dividend[WIDTH-1]);
      dvsWork <= condNeg(divisor, op_signed && divisor[WIDTH-1]);
      remWork <= '0;
      qNeg    <= op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      rNeg    <= op_signed && dividend[WIDTH-1];
    end else if (state == Iter) begin
      if (!trial[WIDTH]) begin
        remWork <= trial[WIDTH-1:0];
        quoWork <= {quoWork[WIDTH-2:0], 1'b1};
      end else begin
        remWork <= {remWork[WIDTH-2:0], quoWork[WIDTH-1]};
        quoWork <= {quoWork[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_exec_divider.sv
// tb_exec_divider
//   Directed bench for exec_divider (WIDTH=32). A behavioural model computes
//   expected quotient/remainder with plain integer division; a monitor checks
//   every done pulse against it, and each directed vector also carries
//   hand-computed literal results and cycle-exact stall/done expectations.
module tb_exec_divider;

  logic        clk = 1'b0;
  logic        reset, start, op_signed, flush;
  logic [31:0] dividend, divisor;
  logic        busy, done, stall_e;
  logic [31:0] quotient, remainder;

  int nVec = 0;
  int nErr = 0;
  logic [31:0] expQ[$];
  logic [31:0] expR[$];
  logic [31:0] monQ, monR;

  exec_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .stall_e(stall_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'd0;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  // Every done pulse must match the oldest pending model result.
  always @(negedge clk) begin
    #2;
    if (done) begin
      if (expQ.size() == 0) begin
        nVec++;
        nErr++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        monQ = expQ.pop_front();
        monR = expR.pop_front();
        check("model_quotient", quotient, monQ);
        check("model_remainder", remainder, monR);
      end
    end
  end

  // Start an operation in cycle 0; optionally flush / reset / issue a stray
  // start at cycle flushAt / resetAt / startAt (negative = never).
  task automatic runDiv(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] litQ, input logic [31:0] litR,
                        input int flushAt, input int resetAt, input int startAt);
    int lat;
    logic [31:0] mq, mr, heldQ, heldR;
    lat   = (b == 32'd0) ? 1 : 34;
    heldQ = quotient;
    heldR = remainder;
    @(negedge clk);
    start = 1'b1; op_signed = s; dividend = a; divisor = b;
    if (flushAt < 0 && resetAt < 0) begin
      model(s, a, b, mq, mr);
      expQ.push_back(mq);
      expR.push_back(mr);
    end
    #1 check("stall_cycle0", 32'(stall_e), 32'd1);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      start = (k == startAt);
      flush = (k == flushAt);
      reset = (k == resetAt);
      if (k == startAt) begin
        dividend = ~a; divisor = 32'd3; op_signed = ~s;
      end
      #1;
      if (flushAt >= 0 && k == flushAt + 1) begin
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_held_q", quotient, heldQ);
        check("flush_held_r", remainder, heldR);
        return;
      end
      if (resetAt >= 0 && k == resetAt + 1) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall_e), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        return;
      end
      if (k <= lat) begin
        check("stall", 32'(stall_e), 32'(k < lat));
        check("done", 32'(done), 32'(k == lat));
        check("busy", 32'(busy), 32'd1);
      end else begin
        check("done_after", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
      end
      if (k == lat) begin
        check("lit_quotient", quotient, litQ);
        check("lit_remainder", remainder, litR);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected end of run");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op_signed = 1'b0; flush = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_stall", 32'(stall_e), 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    runDiv(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, -1, -1, -1);
    runDiv(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, -1, -1, -1);
    runDiv(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, -1, -1, -1);
    runDiv(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, -1, -1, -1);
    runDiv(1'b0, 32'h1234_5678, 32'd0, 32'd0, 32'h1234_5678, -1, -1, -1);
    runDiv(1'b1, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'hFFFF_FFF9, -1, -1, -1);
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, -1, -1, -1);
    runDiv(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, -1, -1, -1);
    runDiv(1'b0, 32'd7, 32'd100, 32'd0, 32'd7, -1, -1, -1);
    // Stray start while busy must not disturb the result.
    runDiv(1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, -1, -1, 5);
    // Flush in cycle 10, then a fresh start in cycle 12.
    runDiv(1'b0, 32'd5000, 32'd3, 32'd0, 32'd0, 10, -1, -1);
    runDiv(1'b0, 32'd5000, 32'd3, 32'd1666, 32'd2, -1, -1, -1);
    // Reset in cycle 5 of an SDIV.
    runDiv(1'b1, 32'hFFFF_FF9C, 32'd7, 32'd0, 32'd0, -1, 5, -1);
    runDiv(1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, -1, -1, -1);

    repeat (3) @(negedge clk);
    check("pending_results", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
